// File: rtl/rv_regfile_sb_if.sv
// Bus between decode/issue/writeback and the register file with scoreboard.
interface rv_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            iss_ready;
  logic [AW:0]     pend_cnt;
  logic            all_idle;

  modport master (
    output rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready, pend_cnt, all_idle
  );

  modport slave (
    input  rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready, pend_cnt, all_idle
  );
endinterface

// File: rtl/rv_regfile_sb.sv
// Integer register file with per-register pending-write scoreboard.
// Two combinational read ports, one writeback port (optional same-cycle
// bypass) and an issue port that marks destinations busy until writeback.
module rv_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  rv_regfile_sb_if.slave rf
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;
  logic            all_idle_q;

  logic wr_ok, iss_acc, set_new, clr_old;
  logic rs1_hit, rs2_hit;

  // Register 0 is hardwired only when ZERO_REG is enabled.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Handshake, scoreboard next state and incremental pending counter.
  always_comb begin
    wr_ok   = reset_n && rf.wb_en && !is_zero(rf.wb_addr);
    rf.iss_ready = reset_n && (is_zero(rf.iss_addr) || !pend_q[rf.iss_addr] ||
                               (rf.wb_en && (rf.wb_addr == rf.iss_addr)));
    iss_acc = rf.iss_en && rf.iss_ready && !is_zero(rf.iss_addr);
    // Count only real transitions; a same-address set overrides the clear.
    set_new = iss_acc && !pend_q[rf.iss_addr];
    clr_old = wr_ok && pend_q[rf.wb_addr] &&
              !(iss_acc && (rf.iss_addr == rf.wb_addr));
    pend_d = pend_q;
    if (wr_ok)   pend_d[rf.wb_addr]  = 1'b0;
    if (iss_acc) pend_d[rf.iss_addr] = 1'b1;
    pend_cnt_d = pend_cnt_q + (AW+1)'(set_new) - (AW+1)'(clr_old);
  end

  // Read ports: bypass hit beats stored value; zero register reads as 0.
  always_comb begin
    rs1_hit = (BYPASS != 0) && wr_ok && (rf.wb_addr == rf.rs1_addr);
    rs2_hit = (BYPASS != 0) && wr_ok && (rf.wb_addr == rf.rs2_addr);
    rf.rs1_data = rs1_hit ? rf.wb_data :
                  (is_zero(rf.rs1_addr) ? '0 : rf_q[rf.rs1_addr]);
    rf.rs2_data = rs2_hit ? rf.wb_data :
                  (is_zero(rf.rs2_addr) ? '0 : rf_q[rf.rs2_addr]);
    rf.rs1_busy = !is_zero(rf.rs1_addr) && !rs1_hit && pend_q[rf.rs1_addr];
    rf.rs2_busy = !is_zero(rf.rs2_addr) && !rs2_hit && pend_q[rf.rs2_addr];
  end

  // State update: synchronous active-low reset clears data and scoreboard.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
      all_idle_q <= 1'b1;
    end else begin
      if (wr_ok) rf_q[rf.wb_addr] <= rf.wb_data;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      all_idle_q <= (pend_cnt_d == '0);
    end
  end

  assign rf.pend_cnt = pend_cnt_q;
  assign rf.all_idle = all_idle_q;
endmodule
